// File: rtl/multi_mem_pkg.sv
// Shared types and constants for the multi-cycle memory stage.
// Optional macro ALIGN_CHECK_EN adds the address LSBs to the read tag.
package multi_mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    localparam logic IORD_INSTR = 1'b0;
    localparam logic IORD_DATA  = 1'b1;

    typedef struct packed {
        logic       valid;
        logic       is_data;
`ifdef ALIGN_CHECK_EN
        logic [1:0] lsb;
`endif
    } rd_tag_t;

    function automatic logic rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/multi_mem_stage_if.sv
// Unified instruction/data BRAM port: the stage is master, the BRAM is slave.
interface multi_mem_stage_if #(
    parameter int MEM_AW = 14
);

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_en,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_en,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/multi_rd_tag_pipe.sv
// DEPTH-stage shift register of read tags; the head lines up with BRAM read data.
module multi_rd_tag_pipe
    import multi_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t push,
    output rd_tag_t head
);

    rd_tag_t stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head = stages[DEPTH-1];

endmodule

// File: rtl/multi_mem_stage.sv
// Memory stage of the multi-cycle core: BRAM address/strobe generation, IR/MDR, read tracking.
// Optional macro ALIGN_CHECK_EN enables misaligned-access detection (align_err).
module multi_mem_stage
    import multi_mem_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IorD,
    input  logic                 MemWrite,
    input  logic                 IRWrite,
    input  logic [31:0]          PC,
    input  logic [31:0]          ALUOut,
    input  logic [31:0]          WriteData,
    multi_mem_stage_if.master    mem,
    output logic [31:0]          Instr,
    output logic [31:0]          Data,
    output logic                 rd_valid,
    output logic                 rd_is_data,
    output logic                 prot_err,
    output logic                 align_err,
    output logic [CNT_W-1:0]     fetch_count
);

    generate
        if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
            $error("multi_mem_stage: RD_LAT must be within 1..4");
        end
    endgenerate

    logic [31:0] adr;
    logic        MemWrite_q;
    logic        we_edge;
    logic        wr_prot;
    logic        misaligned_wr;
    logic        lsb_ok;
    logic        write_now;
    logic        load_mdr;
    logic        load_ir;
    logic        ir_prot;
    logic        unused_adr_bits;
    rd_tag_t     push_tag;
    rd_tag_t     head_tag;

    assign adr             = (IorD == IORD_DATA) ? ALUOut : PC;
    assign unused_adr_bits = ^{adr[31:MEM_AW+2], adr[1:0]};

    assign we_edge = MemWrite & ~MemWrite_q;
    assign wr_prot = MemWrite & (IorD == IORD_INSTR);

`ifdef ALIGN_CHECK_EN
    assign misaligned_wr = we_edge & (adr[1:0] != 2'b00);
    assign lsb_ok        = (head_tag.lsb == 2'b00);
`else
    assign misaligned_wr = 1'b0;
    assign lsb_ok        = 1'b1;
`endif

    // Only the first cycle of a held MemWrite strobes the BRAM.
    assign write_now = ~rst & we_edge & ~wr_prot & ~misaligned_wr;

    assign mem.mem_addr  = adr[MEM_AW+1:2];
    assign mem.mem_en    = ~rst;
    assign mem.mem_we    = write_now;
    assign mem.mem_wdata = WriteData;

    always_comb begin
        push_tag         = '0;
        push_tag.valid   = ~write_now;
        push_tag.is_data = IorD;
`ifdef ALIGN_CHECK_EN
        push_tag.lsb     = adr[1:0];
`endif
    end

    multi_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (push_tag),
        .head (head_tag)
    );

    assign rd_valid   = head_tag.valid;
    assign rd_is_data = head_tag.is_data;

    assign load_mdr = head_tag.valid & head_tag.is_data & lsb_ok;
    assign load_ir  = IRWrite & head_tag.valid & ~head_tag.is_data & lsb_ok;
    assign ir_prot  = IRWrite & ~(head_tag.valid & ~head_tag.is_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemWrite_q <= 1'b0;
        end else begin
            MemWrite_q <= MemWrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instr       <= '0;
            Data        <= '0;
            fetch_count <= '0;
        end else begin
            if (load_mdr) begin
                Data <= mem.mem_rdata;
            end
            if (load_ir) begin
                Instr <= mem.mem_rdata;
                if (fetch_count != {CNT_W{1'b1}}) begin
                    fetch_count <= fetch_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prot_err <= 1'b0;
        end else if (wr_prot | ir_prot) begin
            prot_err <= 1'b1;
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (misaligned_wr | (head_tag.valid & ~lsb_ok)) begin
            align_err <= 1'b1;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_mem_stage.sv
// Directed self-checking bench for multi_mem_stage (RD_LAT=2, CNT_W=2 to reach saturation quickly).
module tb_multi_mem_stage;

    logic        clk;
    logic        rst;
    logic        IorD;
    logic        MemWrite;
    logic        IRWrite;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic [31:0] WriteData;
    logic [31:0] Instr;
    logic [31:0] Data;
    logic        rd_valid;
    logic        rd_is_data;
    logic        prot_err;
    logic        align_err;
    logic [1:0]  fetch_count;

    int testsRun;
    int testsFailed;

    multi_mem_stage_if #(.MEM_AW(14)) mem_bus ();

    multi_mem_stage #(
        .MEM_AW (14),
        .RD_LAT (2),
        .CNT_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .PC          (PC),
        .ALUOut      (ALUOut),
        .WriteData   (WriteData),
        .mem         (mem_bus),
        .Instr       (Instr),
        .Data        (Data),
        .rd_valid    (rd_valid),
        .rd_is_data  (rd_is_data),
        .prot_err    (prot_err),
        .align_err   (align_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iord, input logic mw, input logic irw,
                                 input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [31:0] rdata);
        IorD              = iord;
        MemWrite          = mw;
        IRWrite           = irw;
        PC                = pc;
        ALUOut            = alu;
        WriteData         = wd;
        mem_bus.mem_rdata = rdata;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("reset_mem_en",     {31'b0, mem_bus.mem_en}, 32'h0);
        checkOutput("reset_mem_we",     {31'b0, mem_bus.mem_we}, 32'h0);
        checkOutput("reset_instr",      Instr, 32'h0);
        checkOutput("reset_data",       Data, 32'h0);
        checkOutput("reset_count",      {30'b0, fetch_count}, 32'h0);
        checkOutput("reset_prot",       {31'b0, prot_err}, 32'h0);
        checkOutput("reset_align",      {31'b0, align_err}, 32'h0);
        checkOutput("reset_rd_valid",   {31'b0, rd_valid}, 32'h0);

        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("run_mem_en", {31'b0, mem_bus.mem_en}, 32'h1);

        // Instruction fetch
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0);
        checkOutput("fetch_addr", {18'b0, mem_bus.mem_addr}, 32'h4);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0000_0014, 32'h0, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h0000_0018, 32'h0, 32'h0, 32'h2008_0005);
        checkOutput("fetch_rd_valid",   {31'b0, rd_valid}, 32'h1);
        checkOutput("fetch_rd_is_data", {31'b0, rd_is_data}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("fetch_instr", Instr, 32'h2008_0005);
        checkOutput("fetch_count", {30'b0, fetch_count}, 32'h1);

        // Data load
        nextCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0000_0104, 32'h0, 32'h0);
        checkOutput("load_addr", {18'b0, mem_bus.mem_addr}, 32'h41);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        checkOutput("load_rd_valid",   {31'b0, rd_valid}, 32'h1);
        checkOutput("load_rd_is_data", {31'b0, rd_is_data}, 32'h1);
        checkOutput("load_data_before", Data, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("load_data",      Data, 32'hDEAD_BEEF);
        checkOutput("load_instr_kept", Instr, 32'h2008_0005);

        // Held store: one strobe, invalid tag at the head two cycles later
        nextCycle();
        applyStimulus(1, 1, 0, 32'h0, 32'h0000_0020, 32'h1234_5678, 32'h0);
        checkOutput("store_we_first", {31'b0, mem_bus.mem_we}, 32'h1);
        checkOutput("store_addr",     {18'b0, mem_bus.mem_addr}, 32'h8);
        checkOutput("store_wdata",    mem_bus.mem_wdata, 32'h1234_5678);
        nextCycle();
        applyStimulus(1, 1, 0, 32'h0, 32'h0000_0020, 32'h1234_5678, 32'h0);
        checkOutput("store_we_second", {31'b0, mem_bus.mem_we}, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 0, 32'h0, 32'h0000_0020, 32'h1234_5678, 32'h0);
        checkOutput("store_we_third",   {31'b0, mem_bus.mem_we}, 32'h0);
        checkOutput("store_head_inval", {31'b0, rd_valid}, 32'h0);

        // IRWrite on a data-tagged completion
        nextCycle();
        applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h5555_AAAA);
        checkOutput("irprot_rd_valid",   {31'b0, rd_valid}, 32'h1);
        checkOutput("irprot_rd_is_data", {31'b0, rd_is_data}, 32'h1);
        checkOutput("irprot_prot_before", {31'b0, prot_err}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("irprot_prot",  {31'b0, prot_err}, 32'h1);
        checkOutput("irprot_instr", Instr, 32'h2008_0005);
        checkOutput("irprot_count", {30'b0, fetch_count}, 32'h1);
        checkOutput("irprot_data",  Data, 32'h5555_AAAA);

        // Async reset one cycle after a fetch
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0000_0030, 32'h0, 32'h0, 32'h0);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("arst_instr",    Instr, 32'h0);
        checkOutput("arst_data",     Data, 32'h0);
        checkOutput("arst_count",    {30'b0, fetch_count}, 32'h0);
        checkOutput("arst_prot",     {31'b0, prot_err}, 32'h0);
        checkOutput("arst_mem_en",   {31'b0, mem_bus.mem_en}, 32'h0);
        checkOutput("arst_rd_valid", {31'b0, rd_valid}, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D);
        checkOutput("arst_head_inval", {31'b0, rd_valid}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("arst_no_ir_load", Instr, 32'h0);
        checkOutput("arst_no_count",   {30'b0, fetch_count}, 32'h0);
        checkOutput("arst_prot_set",   {31'b0, prot_err}, 32'h1);

        // Store with IorD=0
        nextCycle();
        rst = 1'b1;
        #1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("wprot_prot_clear", {31'b0, prot_err}, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 32'h0000_0040, 32'h0, 32'h0000_AAAA, 32'h0);
        checkOutput("wprot_we", {31'b0, mem_bus.mem_we}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("wprot_prot", {31'b0, prot_err}, 32'h1);
        nextCycle();
        nextCycle();
        checkOutput("wprot_sticky", {31'b0, prot_err}, 32'h1);

        // Misaligned store
        nextCycle();
        applyStimulus(1, 1, 0, 32'h0, 32'h0000_0022, 32'h0BAD_F00D, 32'h0);
`ifdef ALIGN_CHECK_EN
        checkOutput("align_we", {31'b0, mem_bus.mem_we}, 32'h0);
`else
        checkOutput("align_we",   {31'b0, mem_bus.mem_we}, 32'h1);
        checkOutput("align_addr", {18'b0, mem_bus.mem_addr}, 32'h8);
`endif
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ALIGN_CHECK_EN
        checkOutput("align_err", {31'b0, align_err}, 32'h1);
`else
        checkOutput("align_err", {31'b0, align_err}, 32'h0);
`endif

        // Fetch counter saturation (CNT_W=2 saturates at 3)
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h1111_0000 + i);
            checkOutput("sat_count_step", {30'b0, fetch_count}, i);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        checkOutput("sat_count_final", {30'b0, fetch_count}, 32'h3);
        checkOutput("sat_instr_last",  Instr, 32'h1111_0003);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
